// File: rtl/arq_pkg.sv
// Shared types for the ARQ link transmit path: frame kinds, the output
// register state and a default-width link frame record.
package arq_pkg;

  localparam int SEQ_W_DEF  = 4;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    KIND_DATA      = 2'd0,
    KIND_ACK       = 2'd1,
    KIND_KEEPALIVE = 2'd2
  } frame_kind_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  typedef struct packed {
    frame_kind_t           kind;
    logic [SEQ_W_DEF-1:0]  seq;
    logic [DATA_W_DEF-1:0] data;
  } link_frame_t;

endpackage

// File: rtl/arq_burst_arbiter.sv
// Priority grant between ack requests and payload frames. Acks win, but
// only ACK_BURST_MAX of them in a row while a payload is waiting, so the
// payload side always makes progress.
module arq_burst_arbiter
  import arq_pkg::*;
#(
  parameter int ACK_BURST_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic pay_valid,
  input  logic ack_valid,
  output logic grant_ack,
  output logic grant_data
);

  localparam int RUN_W = $clog2(ACK_BURST_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(ACK_BURST_MAX);

  logic [RUN_W-1:0] ack_run_q, ack_run_d;

  // Grant decision, only meaningful when the output register can take a frame.
  always_comb begin
    grant_ack  = load && ack_valid && (!pay_valid || (ack_run_q < RUN_MAX));
    grant_data = load && pay_valid && !grant_ack;
  end

  // Consecutive-ack counter; only counts acks that overtook a waiting payload.
  always_comb begin
    ack_run_d = ack_run_q;
    if (!pay_valid || grant_data) begin
      ack_run_d = '0;
    end else if (grant_ack && (ack_run_q != RUN_MAX)) begin
      ack_run_d = ack_run_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_run_q <= '0;
    end else begin
      ack_run_q <= ack_run_d;
    end
  end

endmodule

// File: rtl/arq_link_scheduler.sv
// Transmit-side link scheduler: merges ack frames and payload frames onto
// one registered output stream. Define ARQ_SCHED_KEEPALIVE_EN to build in
// the idle keepalive generator.
module arq_link_scheduler
  import arq_pkg::*;
#(
  parameter int SEQ_W         = 4,
  parameter int DATA_W        = 32,
  parameter int ACK_BURST_MAX = 4,
  parameter int IDLE_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pay_valid,
  output logic              pay_ready,
  input  logic [SEQ_W-1:0]  pay_seq,
  input  logic [DATA_W-1:0] pay_data,
  input  logic              ack_valid,
  output logic              ack_ready,
  input  logic [SEQ_W-1:0]  ack_seq,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [SEQ_W-1:0]  out_seq,
  output logic [DATA_W-1:0] out_data
);

  out_state_t        state_q, state_d;
  frame_kind_t       kind_q, kind_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic load_en;
  logic grant_ack, grant_data, grant_ka;

  // Register may be written when empty or when its frame leaves this cycle;
  // reset blocks all grants so no input handshake happens while held.
  assign load_en = ((state_q == ST_EMPTY) || out_ready) && !rst;

  arq_burst_arbiter #(
    .ACK_BURST_MAX(ACK_BURST_MAX)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .load      (load_en),
    .pay_valid (pay_valid),
    .ack_valid (ack_valid),
    .grant_ack (grant_ack),
    .grant_data(grant_data)
  );

`ifdef ARQ_SCHED_KEEPALIVE_EN
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  assign grant_ka = load_en && !grant_ack && !grant_data && (idle_cnt_q == IDLE_MAX);

  // Idle timer: restarts on every output handshake and also when a keepalive
  // is loaded, so an expired timer cannot issue back-to-back keepalives.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (((state_q == ST_FULL) && out_ready) || grant_ka) begin
      idle_cnt_d = '0;
    end else if ((state_q == ST_EMPTY) && !grant_ack && !grant_data &&
                 (idle_cnt_q != IDLE_MAX)) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  // Idle timer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic unused_idle_cfg;
  assign unused_idle_cfg = ^IDLE_TIMEOUT;
  assign grant_ka        = 1'b0;
`endif

  // Output register next state: load the granted frame, or drain to empty.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    seq_d   = seq_q;
    data_d  = data_q;
    if (load_en) begin
      if (grant_ack) begin
        state_d = ST_FULL;
        kind_d  = KIND_ACK;
        seq_d   = ack_seq;
        data_d  = '0;
      end else if (grant_data) begin
        state_d = ST_FULL;
        kind_d  = KIND_DATA;
        seq_d   = pay_seq;
        data_d  = pay_data;
      end else if (grant_ka) begin
        state_d = ST_FULL;
        kind_d  = KIND_KEEPALIVE;
        seq_d   = '0;
        data_d  = '0;
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  // Output register; reset discards any held frame immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      kind_q  <= KIND_DATA;
      seq_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      seq_q   <= seq_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_kind  = kind_q;
  assign out_seq   = seq_q;
  assign out_data  = data_q;
  assign pay_ready = grant_data;
  assign ack_ready = grant_ack;

endmodule

// File: tb/tb_arq_link_scheduler.sv
module tb_arq_link_scheduler;

  logic        clk;
  logic        rst;
  logic        pay_valid, pay_ready;
  logic [3:0]  pay_seq;
  logic [31:0] pay_data;
  logic        ack_valid, ack_ready;
  logic [3:0]  ack_seq;
  logic        out_valid, out_ready;
  logic [1:0]  out_kind;
  logic [3:0]  out_seq;
  logic [31:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  arq_link_scheduler #(
    .SEQ_W(4), .DATA_W(32), .ACK_BURST_MAX(4), .IDLE_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_seq(pay_seq), .pay_data(pay_data),
    .ack_valid(ack_valid), .ack_ready(ack_ready), .ack_seq(ack_seq),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_seq(out_seq), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        pv;
    logic [3:0]  ps;
    logic [31:0] pd;
    logic        av;
    logic [3:0]  as;
    logic        ordy;
    logic        e_pr;
    logic        e_ar;
    logic        e_ov;
    logic [1:0]  e_k;
    logic [3:0]  e_s;
    logic [31:0] e_d;
  } vec_t;

  vec_t vt[16];

  // Output stability monitor: a stalled frame must stay put until accepted.
  logic        prev_stall = 1'b0;
  logic [1:0]  pk;
  logic [3:0]  pseq;
  logic [31:0] pdat;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stable valid", out_valid, 1);
        chk("stable kind", out_kind, pk);
        chk("stable seq", out_seq, pseq);
        chk("stable data", out_data, pdat);
      end
      prev_stall = out_valid && !out_ready;
      pk   = out_kind;
      pseq = out_seq;
      pdat = out_data;
    end
  end

  initial begin
    int a_cnt, p_cnt;
    logic [1:0]  last_k;
    logic [3:0]  last_s;
    logic [31:0] last_d;
    logic        hs_a, hs_p;

    //          pv ps  pd            av as  rdy  pr ar  ov k  s   d
    vt[0]  = '{1, 3,  32'hDEADBEEF, 0, 0,  1,   1, 0,  1, 0, 3,  32'hDEADBEEF};
    vt[1]  = '{0, 0,  0,            0, 0,  1,   0, 0,  0, 0, 0,  0};
    vt[2]  = '{0, 0,  0,            1, 5,  1,   0, 1,  1, 1, 5,  0};
    vt[3]  = '{1, 7,  32'h11,       1, 6,  0,   0, 0,  1, 1, 5,  0};
    vt[4]  = '{1, 7,  32'h11,       1, 6,  1,   0, 1,  1, 1, 6,  0};
    vt[5]  = '{1, 7,  32'h11,       1, 8,  1,   0, 1,  1, 1, 8,  0};
    vt[6]  = '{1, 7,  32'h11,       1, 9,  1,   0, 1,  1, 1, 9,  0};
    vt[7]  = '{1, 7,  32'h11,       1, 10, 1,   0, 1,  1, 1, 10, 0};
    vt[8]  = '{1, 7,  32'h11,       1, 11, 1,   1, 0,  1, 0, 7,  32'h11};
    vt[9]  = '{0, 0,  0,            1, 11, 1,   0, 1,  1, 1, 11, 0};
    vt[10] = '{1, 12, 32'hCAFEF00D, 0, 0,  1,   1, 0,  1, 0, 12, 32'hCAFEF00D};
    vt[11] = '{1, 13, 32'h0BADF00D, 0, 0,  0,   0, 0,  1, 0, 12, 32'hCAFEF00D};
    vt[12] = '{1, 13, 32'h0BADF00D, 0, 0,  1,   1, 0,  1, 0, 13, 32'h0BADF00D};
    vt[13] = '{0, 0,  0,            0, 0,  0,   0, 0,  1, 0, 13, 32'h0BADF00D};
    vt[14] = '{0, 0,  0,            0, 0,  1,   0, 0,  0, 0, 0,  0};
    vt[15] = '{0, 0,  0,            1, 2,  0,   0, 1,  1, 1, 2,  0};

    // Reset with inputs active: nothing may be accepted or presented.
    rst = 1'b1;
    pay_valid = 1'b1; pay_seq = 4'd1; pay_data = 32'h5; ack_valid = 1'b1; ack_seq = 4'd2;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_kind", out_kind, 0);
    chk("rst out_seq", out_seq, 0);
    chk("rst out_data", out_data, 0);
    chk("rst pay_ready", pay_ready, 0);
    chk("rst ack_ready", ack_ready, 0);
    chk("rst ack_run", dut.u_arb.ack_run_q, 0);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 16; i++) begin
      pay_valid = vt[i].pv; pay_seq = vt[i].ps; pay_data = vt[i].pd;
      ack_valid = vt[i].av; ack_seq = vt[i].as; out_ready = vt[i].ordy;
      #1;
      chk($sformatf("v%0d pay_ready", i), pay_ready, vt[i].e_pr);
      chk($sformatf("v%0d ack_ready", i), ack_ready, vt[i].e_ar);
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), out_valid, vt[i].e_ov);
      if (vt[i].e_ov) begin
        chk($sformatf("v%0d out_kind", i), out_kind, vt[i].e_k);
        chk($sformatf("v%0d out_seq", i), out_seq, vt[i].e_s);
        chk($sformatf("v%0d out_data", i), out_data, vt[i].e_d);
      end
    end

    // Burst fairness: both sources always valid, sink always ready.
    a_cnt = 0; p_cnt = 0;
    last_k = 0; last_s = 0; last_d = 0;
    pay_valid = 1'b1; ack_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      ack_seq  = 4'(a_cnt);
      pay_seq  = 4'(p_cnt);
      pay_data = 32'h100 + 32'(p_cnt);
      #1;
      chk($sformatf("burst%0d ack_ready", i), ack_ready, (i % 5) != 4);
      chk($sformatf("burst%0d pay_ready", i), pay_ready, (i % 5) == 4);
      hs_a = ack_ready; hs_p = pay_ready;
      if ((i % 5) != 4) begin
        last_k = 2'd1; last_s = 4'(a_cnt); last_d = 32'h0;
      end else begin
        last_k = 2'd0; last_s = 4'(p_cnt); last_d = 32'h100 + 32'(p_cnt);
      end
      @(posedge clk); #1;
      chk($sformatf("burst%0d out_valid", i), out_valid, 1);
      chk($sformatf("burst%0d out_kind", i), out_kind, last_k);
      chk($sformatf("burst%0d out_seq", i), out_seq, last_s);
      chk($sformatf("burst%0d out_data", i), out_data, last_d);
      if (hs_a) a_cnt++;
      if (hs_p) p_cnt++;
    end

    // Stall for 5 cycles with both sources pending: nothing accepted, frame held.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall%0d pay_ready", i), pay_ready, 0);
      chk($sformatf("stall%0d ack_ready", i), ack_ready, 0);
      chk($sformatf("stall%0d out_kind", i), out_kind, last_k);
      chk($sformatf("stall%0d out_seq", i), out_seq, last_s);
      chk($sformatf("stall%0d out_data", i), out_data, last_d);
      @(posedge clk); #1;
    end
    pay_valid = 1'b0; ack_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("release handshake", out_valid && out_ready, 1);
    @(posedge clk); #1;
    chk("release drained", out_valid, 0);

    // Idle period after the last handshake.
`ifdef ARQ_SCHED_KEEPALIVE_EN
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d out_valid", k), out_valid, k == 9);
    end
    chk("keepalive kind", out_kind, 2);
    chk("keepalive seq", out_seq, 0);
    chk("keepalive data", out_data, 0);
    @(posedge clk); #1;
    chk("keepalive drained", out_valid, 0);
`else
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d out_valid", k), out_valid, 0);
    end
`endif

    // Reset while a frame is held.
    pay_valid = 1'b1; pay_seq = 4'd9; pay_data = 32'h99;
    ack_valid = 1'b1; ack_seq = 4'd4; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre-rst out_valid", out_valid, 1);
    chk("pre-rst out_kind", out_kind, 1);
    chk("pre-rst ack_run", dut.u_arb.ack_run_q, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid-rst out_valid", out_valid, 0);
    chk("mid-rst pay_ready", pay_ready, 0);
    chk("mid-rst ack_ready", ack_ready, 0);
    chk("mid-rst ack_run", dut.u_arb.ack_run_q, 0);
`ifdef ARQ_SCHED_KEEPALIVE_EN
    chk("mid-rst idle_cnt", dut.idle_cnt_q, 0);
`endif
    @(posedge clk); #1;
    chk("rst held out_valid", out_valid, 0);
    rst = 1'b0;
    pay_valid = 1'b0; ack_valid = 1'b0;
    @(posedge clk); #1;
    chk("post-rst out_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
